// File: rtl/store_retire_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_retire_buffer_pkg
//   Shared types and sizing constants for the retired-store buffer.
//   XLEN          : machine word width
//   RSB_DEPTH     : buffer entries (power of 2, >= 4)
//   RSB_W         : pointer width, log2(RSB_DEPTH)
//   SQ_ENTRY_PACKET : packet presented to the dcache store port
//   rsb_entry_t   : payload held per buffer entry (no ready bit)
// ---------------------------------------------------------------------------
package store_retire_buffer_pkg;

    localparam int XLEN      = 32;
    localparam int RSB_DEPTH = 8;
    localparam int RSB_W     = $clog2(RSB_DEPTH);

    typedef struct packed {
        logic            ready;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      usebytes;
    } SQ_ENTRY_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [3:0]      usebytes;
    } rsb_entry_t;

endpackage

// File: rtl/store_retire_buffer_ld_match.sv
// ---------------------------------------------------------------------------
// rsb_ld_match
//   Word-address compare of each load against every buffer entry. Only
//   instantiated when SQ_LD_CONFLICT_EN is defined.
//   entry_live_i : entry is between head and tail and writes at least a byte
//   entry_word_i : entry word address (byte address >> 2)
//   ld_word_i    : load word addresses
//   conflict_o   : load i hits a live entry
// ---------------------------------------------------------------------------
module rsb_ld_match #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 30,
    parameter int NUM_LD = 2
) (
    input  logic [DEPTH-1:0]              entry_live_i,
    input  logic [DEPTH-1:0][WORD_W-1:0]  entry_word_i,
    input  logic [NUM_LD-1:0][WORD_W-1:0] ld_word_i,
    output logic [NUM_LD-1:0]             conflict_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any
        // conditional assignment, so no latch can be inferred.
        conflict_o = '0;
        for (int l = 0; l < NUM_LD; l++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (entry_live_i[e] && (entry_word_i[e] == ld_word_i[l])) begin
                    conflict_o[l] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_retire_buffer.sv
// ---------------------------------------------------------------------------
// store_retire_buffer
//   In-order FIFO of retired stores between ROB retire and the dcache store
//   port. Takes up to three stores per cycle (slot 2 oldest), presents the
//   oldest three to the dcache, and drops the leading run of unstalled slots.
//
// Ports
//   clock, reset      : single clock, synchronous active-high reset
//   retire_en[2:0]    : retiring store valid per ROB slot (slot 2 oldest)
//   retire_addr/data  : word-aligned address and data per slot
//   retire_usebytes   : byte enables per slot
//   rsb_free_num      : registered free-entry count
//   rsb_empty         : no buffered stores
//   sq_in[2:0]        : packets to dcache, sq_in[2] = oldest entry
//   sq_stall[2:0]     : dcache cannot accept slot i this cycle
//   ld_addr_in[1:0]   : load addresses           (SQ_LD_CONFLICT_EN only)
//   ld_conflict[1:0]  : load hits buffered store (SQ_LD_CONFLICT_EN only)
//
// Configuration macro: SQ_LD_CONFLICT_EN enables the load-conflict ports.
// ---------------------------------------------------------------------------
module store_retire_buffer
    import store_retire_buffer_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                retire_en,
    input  logic [2:0][XLEN-1:0]      retire_addr,
    input  logic [2:0][XLEN-1:0]      retire_data,
    input  logic [2:0][3:0]           retire_usebytes,
    output logic [RSB_W:0]            rsb_free_num,
    output logic                      rsb_empty,
    output SQ_ENTRY_PACKET [2:0]      sq_in,
`ifdef SQ_LD_CONFLICT_EN
    input  logic [1:0][XLEN-1:0]      ld_addr_in,
    output logic [1:0]                ld_conflict,
`endif
    input  logic [2:0]                sq_stall
);

    rsb_entry_t           entry_q [RSB_DEPTH];
    rsb_entry_t           entry_d [RSB_DEPTH];
    logic [RSB_W-1:0]     head_q, head_d;
    logic [RSB_W-1:0]     tail_q, tail_d;
    logic [RSB_W:0]       count_q, count_d;
    logic [RSB_W:0]       free_q, free_d;

    logic [2:0]           ready;
    logic [2:0]           deq;
    logic [1:0]           n_deq;
    logic [1:0]           n_enq;

    // Presentation and drain decisions use registered state only, so there
    // is no combinational path from retire_en or sq_stall to sq_in.
    always_comb begin
        sq_in = '0;
        ready = '0;
        for (int k = 0; k < 3; k++) begin
            ready[2-k] = (count_q > (RSB_W+1)'(k));
            if (ready[2-k]) begin
                sq_in[2-k] = {1'b1, entry_q[head_q + RSB_W'(k)]};
            end
        end
    end

    // A stalled older slot blocks every younger slot behind it.
    always_comb begin
        deq[2] = ready[2] & ~sq_stall[2];
        deq[1] = deq[2]   & ready[1] & ~sq_stall[1];
        deq[0] = deq[1]   & ready[0] & ~sq_stall[0];
        n_deq  = {1'b0, deq[2]} + {1'b0, deq[1]} + {1'b0, deq[0]};
    end

    // Enqueue compacts valid slots 2,1,0 onto tail; slots beyond the
    // registered free count are dropped (illegal retire).
    always_comb begin
        entry_d = entry_q;
        n_enq   = '0;
        for (int k = 2; k >= 0; k--) begin
            if (retire_en[k] && ((RSB_W+1)'(n_enq) < free_q)) begin
                entry_d[tail_q + RSB_W'(n_enq)] = '{addr:     retire_addr[k],
                                                    data:     retire_data[k],
                                                    usebytes: retire_usebytes[k]};
                n_enq = n_enq + 2'd1;
            end
        end
        head_d  = head_q + RSB_W'(n_deq);
        tail_d  = tail_q + RSB_W'(n_enq);
        count_d = count_q + (RSB_W+1)'(n_enq) - (RSB_W+1)'(n_deq);
        free_d  = (RSB_W+1)'(RSB_DEPTH) - count_d;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            free_q  <= (RSB_W+1)'(RSB_DEPTH);
            // NOTE: the entry array is cleared on reset so stale stores can
            // never be presented; it is small enough to live in flops.
            for (int i = 0; i < RSB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            free_q  <= free_d;
            for (int i = 0; i < RSB_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign rsb_free_num = free_q;
    assign rsb_empty    = (count_q == '0);

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            assert ($countones(retire_en) <= int'(free_q))
                else $error("store_retire_buffer: retire of %0d stores with only %0d free",
                            $countones(retire_en), free_q);
        end
    end
`endif

`ifdef SQ_LD_CONFLICT_EN
    logic [RSB_DEPTH-1:0]             entry_live;
    logic [RSB_DEPTH-1:0][XLEN-3:0]   entry_word;
    logic [1:0][XLEN-3:0]             ld_word;

    // Entry i is valid when its distance from head (mod depth) is below count.
    always_comb begin
        for (int i = 0; i < RSB_DEPTH; i++) begin
            entry_live[i] = ((RSB_W+1)'(RSB_W'(i) - head_q) < count_q)
                            && (entry_q[i].usebytes != 4'b0);
            entry_word[i] = entry_q[i].addr[XLEN-1:2];
        end
        for (int l = 0; l < 2; l++) begin
            ld_word[l] = ld_addr_in[l][XLEN-1:2];
        end
    end

    rsb_ld_match #(
        .DEPTH  (RSB_DEPTH),
        .WORD_W (XLEN-2),
        .NUM_LD (2)
    ) u_ld_match (
        .entry_live_i (entry_live),
        .entry_word_i (entry_word),
        .ld_word_i    (ld_word),
        .conflict_o   (ld_conflict)
    );
`endif

endmodule

// File: tb/tb_store_retire_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_retire_buffer
//   Scoreboard bench for store_retire_buffer (default build). Expected stores
//   are queued when retired and popped as the dcache side drains them.
// ---------------------------------------------------------------------------
module tb_store_retire_buffer;
    import store_retire_buffer_pkg::*;

    logic                    clock;
    logic                    reset;
    logic [2:0]              retire_en;
    logic [2:0][XLEN-1:0]    retire_addr;
    logic [2:0][XLEN-1:0]    retire_data;
    logic [2:0][3:0]         retire_usebytes;
    logic [RSB_W:0]          rsb_free_num;
    logic                    rsb_empty;
    SQ_ENTRY_PACKET [2:0]    sq_in;
    logic [2:0]              sq_stall;

    store_retire_buffer dut (
        .clock           (clock),
        .reset           (reset),
        .retire_en       (retire_en),
        .retire_addr     (retire_addr),
        .retire_data     (retire_data),
        .retire_usebytes (retire_usebytes),
        .rsb_free_num    (rsb_free_num),
        .rsb_empty       (rsb_empty),
        .sq_in           (sq_in),
        .sq_stall        (sq_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int             total = 0;
    int             bad   = 0;
    SQ_ENTRY_PACKET exp_q[$];
    logic [31:0]    next_addr = 32'h0;
    logic           use_fixed = 1'b0;
    logic [31:0]    fixed_data = 32'h0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the scoreboard (called at negedge).
    task automatic check_outputs();
        SQ_ENTRY_PACKET exp_pkt;
        for (int k = 0; k < 3; k++) begin
            exp_pkt = (k < exp_q.size()) ? exp_q[k] : '0;
            check($sformatf("sq_in[%0d]", 2-k), 128'(sq_in[2-k]), 128'(exp_pkt));
        end
        check("free", 128'(rsb_free_num), 128'(RSB_DEPTH - exp_q.size()));
        check("empty", 128'(rsb_empty), 128'(exp_q.size() == 0));
    endtask

    // One clock of stimulus: check, drive, update scoreboard, advance.
    task automatic cycle(input logic [2:0] en, input logic [2:0] stall);
        int             n_deq;
        SQ_ENTRY_PACKET pkt;
        check_outputs();
        retire_en = en;
        sq_stall  = stall;
        for (int k = 2; k >= 0; k--) begin
            retire_addr[k]     = next_addr;
            retire_data[k]     = use_fixed ? fixed_data : $urandom;
            retire_usebytes[k] = 4'($urandom_range(1, 15));
            if (en[k]) next_addr = next_addr + 32'd4;
        end
        n_deq = 0;
        for (int k = 0; k < 3; k++) begin
            if (k < exp_q.size() && !stall[2-k] && n_deq == k) n_deq++;
        end
        repeat (n_deq) void'(exp_q.pop_front());
        for (int k = 2; k >= 0; k--) begin
            if (en[k]) begin
                pkt = '{ready: 1'b1, addr: retire_addr[k], data: retire_data[k],
                        usebytes: retire_usebytes[k]};
                exp_q.push_back(pkt);
            end
        end
        @(posedge clock);
        @(negedge clock);
        retire_en = 3'b000;
    endtask

    initial begin
        logic [2:0] en;
        int         free;
        reset           = 1'b1;
        retire_en       = '0;
        retire_addr     = '0;
        retire_data     = '0;
        retire_usebytes = '0;
        sq_stall        = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state.
        check("rst_free", 128'(rsb_free_num), 128'(8));
        check("rst_empty", 128'(rsb_empty), 128'(1));
        check("rst_sq_in", 128'(sq_in), 128'(0));

        // Single store at 0x100, visible one cycle later.
        next_addr  = 32'h100;
        use_fixed  = 1'b1;
        fixed_data = 32'hDEADBEEF;
        cycle(3'b100, 3'b111);
        use_fixed  = 1'b0;
        check("first_ready", 128'(sq_in[2].ready), 128'(1));
        check("first_addr", 128'(sq_in[2].addr), 128'(32'h100));
        check("first_data", 128'(sq_in[2].data), 128'(32'hDEADBEEF));
        check("first_free", 128'(rsb_free_num), 128'(7));
        cycle(3'b000, 3'b000);

        // Three stores drained in one cycle.
        cycle(3'b111, 3'b000);
        check("three_ready", 128'({sq_in[2].ready, sq_in[1].ready, sq_in[0].ready}), 128'(3'b111));
        cycle(3'b000, 3'b000);
        check("drained_empty", 128'(rsb_empty), 128'(1));

        // Stall on oldest blocks all; stall on youngest lets two go.
        cycle(3'b111, 3'b111);
        cycle(3'b000, 3'b100);
        cycle(3'b000, 3'b001);
        cycle(3'b000, 3'b000);

        // Fill to full, release one, release+retire one, refill.
        cycle(3'b111, 3'b111);
        cycle(3'b111, 3'b111);
        cycle(3'b110, 3'b111);
        check("full_free", 128'(rsb_free_num), 128'(0));
        cycle(3'b000, 3'b011);
        cycle(3'b100, 3'b011);
        check("swap_free", 128'(rsb_free_num), 128'(1));
        cycle(3'b100, 3'b111);
        check("refill_free", 128'(rsb_free_num), 128'(0));
        cycle(3'b000, 3'b000);

        // Reset while stores are still buffered.
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        check("midrst_ready", 128'({sq_in[2].ready, sq_in[1].ready, sq_in[0].ready}), 128'(0));
        check("midrst_free", 128'(rsb_free_num), 128'(8));

        // Walk head to 6, then retire three across the wrap.
        cycle(3'b111, 3'b000);
        cycle(3'b000, 3'b000);
        cycle(3'b111, 3'b000);
        cycle(3'b000, 3'b000);
        cycle(3'b111, 3'b000);
        cycle(3'b000, 3'b011);
        cycle(3'b000, 3'b001);
        cycle(3'b000, 3'b000);

        // Random traffic within the legal retire budget.
        for (int it = 0; it < 300; it++) begin
            free = RSB_DEPTH - exp_q.size();
            en   = 3'($urandom);
            while ($countones(en) > free) en = en & (en - 3'd1);
            cycle(en, 3'($urandom));
        end
        repeat (4) cycle(3'b000, 3'b000);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
